// File: rtl/lcd_refresh_scheduler_pkg.sv
// Shared pet-display definitions for the LCD refresh scheduler.
// Holds the scheduler FSM state encoding, the LCD region codes and the
// default parameter values used by the scheduler and its users.
package lcd_refresh_scheduler_pkg;

   // Default parameter values
   localparam int DEF_MAX_VALUE      = 5;
   localparam int DEF_NUM_FACES      = 9;
   localparam int DEF_HOLDOFF_CYCLES = 8;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

   // LCD region codes carried on lcd_region
   localparam logic REGION_FACE  = 1'b0;   // line 1: face
   localparam logic REGION_STATS = 1'b1;   // line 2: feed/joy/energy

   // Scheduler FSM states
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_HOLDOFF   = 2'd3
   } state_t;

endpackage

// File: rtl/lcd_refresh_scheduler_interval_counter.sv
// Down-counter used by the scheduler for both the lcd_done wait window and
// the holdoff interval.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-low reset, clears the count
//   load       - load load_value (has priority over enable)
//   load_value - value to load; the interval lasts load_value+1 cycles
//   enable     - count down by one per cycle, saturating at zero
//   tc         - terminal count, high while the count is zero
module lcd_refresh_scheduler_interval_counter #(
   parameter int WIDTH = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   output logic             tc
);

   logic [WIDTH-1:0] count_r;

   // Interval count register: load wins over decrement, decrement stops at zero.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_r <= {WIDTH{1'b0}};
      end else if (load) begin
         count_r <= load_value;
      end else if (enable && (count_r != {WIDTH{1'b0}})) begin
         count_r <= count_r - WIDTH'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign tc = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/lcd_refresh_scheduler.sv
// LCD refresh scheduler for the pet display.
// Watches the live pet state, detects which LCD region is stale, and issues
// one region redraw at a time to the LCD controller, with round-robin
// arbitration, a done-timeout and a minimum holdoff between redraws.
// Ports:
//   clk, reset                               - clock; synchronous active-low reset
//   face_in, feed_in, joy_in, energy_in      - live pet state (clamped internally)
//   lcd_done                                 - redraw finished pulse from LCD controller
//   lcd_start, lcd_region                    - redraw request pulse and region select
//   face, feed_value, joy_value, energy_value - snapshot values for the LCD controller
//   busy                                     - high whenever the FSM is not idle
//   timeout_err                              - sticky: lcd_done did not arrive in time
module lcd_refresh_scheduler
   import lcd_refresh_scheduler_pkg::*;
#(
   parameter int MAX_VALUE      = DEF_MAX_VALUE,
   parameter int NUM_FACES      = DEF_NUM_FACES,
   parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [$clog2(NUM_FACES)-1:0]  face_in,
   input  logic [$clog2(MAX_VALUE):0]    feed_in,
   input  logic [$clog2(MAX_VALUE):0]    joy_in,
   input  logic [$clog2(MAX_VALUE):0]    energy_in,
   input  logic                          lcd_done,
   output logic                          lcd_start,
   output logic                          lcd_region,
   output logic [$clog2(NUM_FACES)-1:0]  face,
   output logic [$clog2(MAX_VALUE):0]    feed_value,
   output logic [$clog2(MAX_VALUE):0]    joy_value,
   output logic [$clog2(MAX_VALUE):0]    energy_value,
   output logic                          busy,
   output logic                          timeout_err
);

   localparam int FW       = $clog2(NUM_FACES);
   localparam int VW       = $clog2(MAX_VALUE) + 1;
   localparam int CNT_SPAN = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
   localparam int CW       = $clog2(CNT_SPAN + 1);

   localparam logic [FW-1:0] FACE_MAX     = FW'(NUM_FACES - 1);
   localparam logic [VW-1:0] VAL_MAX      = VW'(MAX_VALUE);
   // The counter runs load_value+1 cycles before tc, hence the -1.
   localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LOAD    = CW'(HOLDOFF_CYCLES - 1);

   state_t          state_r;
   logic            lcd_start_r, lcd_region_r, busy_r, timeout_err_r;
   logic            force_face_r, force_stats_r, last_region_r;
   logic [FW-1:0]   face_r;
   logic [VW-1:0]   feed_r, joy_r, energy_r;

   logic [FW-1:0]   face_c_s;
   logic [VW-1:0]   feed_c_s, joy_c_s, energy_c_s;
   logic            dirty_face_s, dirty_stats_s, any_dirty_s, sel_region_s;
   logic            cnt_load_s, cnt_en_s, cnt_tc_s;
   logic [CW-1:0]   cnt_value_s;

   function automatic logic [VW-1:0] clamp_val(input logic [VW-1:0] v);
      return (v > VAL_MAX) ? VAL_MAX : v;
   endfunction

   // Clamp live inputs and compare against the displayed snapshot.
   always_comb begin
      face_c_s      = (face_in > FACE_MAX) ? FACE_MAX : face_in;
      feed_c_s      = clamp_val(feed_in);
      joy_c_s       = clamp_val(joy_in);
      energy_c_s    = clamp_val(energy_in);
      dirty_face_s  = force_face_r | (face_c_s != face_r);
      dirty_stats_s = force_stats_r | (feed_c_s != feed_r) |
                      (joy_c_s != joy_r) | (energy_c_s != energy_r);
      any_dirty_s   = dirty_face_s | dirty_stats_s;
   end

   // Region arbitration: round-robin when both are dirty, otherwise the dirty one.
   always_comb begin
      if (dirty_face_s && dirty_stats_s) begin
         sel_region_s = ~last_region_r;
      end else if (dirty_stats_s) begin
         sel_region_s = REGION_STATS;
      end else begin
         sel_region_s = REGION_FACE;
      end
   end

   // Counter control: arm the done window on ISSUE, arm holdoff on leaving WAIT_DONE.
   always_comb begin
      cnt_load_s  = 1'b0;
      cnt_en_s    = 1'b0;
      cnt_value_s = HOLD_LOAD;
      case (state_r)
         ST_ISSUE: begin
            cnt_load_s  = 1'b1;
            cnt_value_s = TIMEOUT_LOAD;
         end
         ST_WAIT_DONE: begin
            cnt_en_s = 1'b1;
            if (lcd_done || cnt_tc_s) begin
               cnt_load_s = 1'b1;
            end else begin
               cnt_load_s = 1'b0;
            end
         end
         ST_HOLDOFF: begin
            cnt_en_s = 1'b1;
         end
         default: begin
            cnt_en_s = 1'b0;
         end
      endcase
   end

   lcd_refresh_scheduler_interval_counter #(
      .WIDTH (CW)
   ) u_interval_counter (
      .clk        (clk),
      .reset      (reset),
      .load       (cnt_load_s),
      .load_value (cnt_value_s),
      .enable     (cnt_en_s),
      .tc         (cnt_tc_s)
   );

   // Scheduler FSM: issue, snapshot capture, done/timeout handling, registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r       <= ST_IDLE;
         lcd_start_r   <= 1'b0;
         lcd_region_r  <= REGION_FACE;
         busy_r        <= 1'b0;
         timeout_err_r <= 1'b0;
         force_face_r  <= 1'b1;
         force_stats_r <= 1'b1;
         last_region_r <= REGION_STATS;   // so the face region wins first
         face_r        <= {FW{1'b0}};
         feed_r        <= {VW{1'b0}};
         joy_r         <= {VW{1'b0}};
         energy_r      <= {VW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (any_dirty_s) begin
                  // Snapshot is captured on entry to ISSUE so it is valid with lcd_start.
                  state_r       <= ST_ISSUE;
                  busy_r        <= 1'b1;
                  lcd_start_r   <= 1'b1;
                  lcd_region_r  <= sel_region_s;
                  last_region_r <= sel_region_s;
                  if (sel_region_s == REGION_FACE) begin
                     face_r       <= face_c_s;
                     force_face_r <= 1'b0;
                  end else begin
                     feed_r        <= feed_c_s;
                     joy_r         <= joy_c_s;
                     energy_r      <= energy_c_s;
                     force_stats_r <= 1'b0;
                  end
               end
            end
            ST_ISSUE: begin
               lcd_start_r <= 1'b0;
               state_r     <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (lcd_done) begin
                  state_r <= ST_HOLDOFF;
               end else if (cnt_tc_s) begin
                  // Redraw presumed lost: flag it and force the region again.
                  timeout_err_r <= 1'b1;
                  state_r       <= ST_HOLDOFF;
                  if (lcd_region_r == REGION_FACE) begin
                     force_face_r <= 1'b1;
                  end else begin
                     force_stats_r <= 1'b1;
                  end
               end
            end
            ST_HOLDOFF: begin
               if (cnt_tc_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               busy_r      <= 1'b0;
               lcd_start_r <= 1'b0;
            end
         endcase
      end
   end

   assign lcd_start    = lcd_start_r;
   assign lcd_region   = lcd_region_r;
   assign busy         = busy_r;
   assign timeout_err  = timeout_err_r;
   assign face         = face_r;
   assign feed_value   = feed_r;
   assign joy_value    = joy_r;
   assign energy_value = energy_r;

endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// Self-checking bench for lcd_refresh_scheduler: directed scenarios plus a
// randomized phase, all checked against a transaction-window reference model.
module tb_lcd_refresh_scheduler;

   localparam int MAXV = 5;
   localparam int NF   = 9;
   localparam int H    = 8;
   localparam int T    = 1024;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] face_in = 4'd0, feed_in = 4'd0, joy_in = 4'd0, energy_in = 4'd0;
   logic       lcd_done = 1'b0;
   logic       lcd_start, lcd_region, busy, timeout_err;
   logic [3:0] face, feed_value, joy_value, energy_value;

   lcd_refresh_scheduler #(
      .MAX_VALUE(MAXV), .NUM_FACES(NF), .HOLDOFF_CYCLES(H), .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk), .reset(reset),
      .face_in(face_in), .feed_in(feed_in), .joy_in(joy_in), .energy_in(energy_in),
      .lcd_done(lcd_done), .lcd_start(lcd_start), .lcd_region(lcd_region),
      .face(face), .feed_value(feed_value), .joy_value(joy_value),
      .energy_value(energy_value), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: displayed values, force flags, round-robin memory and
   // the edge-number windows in which the scheduler is occupied.
   int cyc = 0;
   int idle_edge = 0;      // first edge at which a new issue may happen
   bit outst = 1'b0;       // an issued redraw awaits done/timeout
   int s_edge = 0;         // edge at which the outstanding redraw was issued
   bit m_reg = 1'b0;
   bit m_last = 1'b1;
   bit m_force [2] = '{1'b1, 1'b1};
   int m_face = 0, m_feed = 0, m_joy = 0, m_energy = 0;
   bit m_terr = 1'b0;
   bit auto_done = 1'b1;
   int done_dly = 5;
   bit spurious_en = 1'b0;
   int n_starts = 0, n_r1 = 0;
   int st_edge[$];
   bit st_reg[$];

   function automatic int clampv(input logic [3:0] v);
      return (int'(v) > MAXV) ? MAXV : int'(v);
   endfunction

   function automatic int clampf(input logic [3:0] v);
      return (int'(v) >= NF) ? NF - 1 : int'(v);
   endfunction

   function automatic bit m_dirty_face();
      return m_force[0] || (clampf(face_in) != m_face);
   endfunction

   function automatic bit m_dirty_stats();
      return m_force[1] || (clampv(feed_in) != m_feed) ||
             (clampv(joy_in) != m_joy) || (clampv(energy_in) != m_energy);
   endfunction

   function automatic bit settled();
      return !outst && (cyc + 1 >= idle_edge) && !m_dirty_face() && !m_dirty_stats();
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: drive lcd_done, advance the model over the edge, compare outputs.
   task automatic tick();
      int e;
      bit df, ds, exp_start, sel;
      e = cyc + 1;
      if (outst && auto_done && (e == s_edge + 1 + done_dly)) lcd_done = 1'b1;
      else if (!outst && spurious_en && ($urandom_range(0, 7) == 0)) lcd_done = 1'b1;
      else lcd_done = 1'b0;
      @(posedge clk);
      cyc = e;
      exp_start = 1'b0;
      sel = 1'b0;
      if (!reset) begin
         m_force[0] = 1'b1; m_force[1] = 1'b1; m_last = 1'b1;
         m_face = 0; m_feed = 0; m_joy = 0; m_energy = 0;
         m_terr = 1'b0; outst = 1'b0; idle_edge = e + 1;
      end else begin
         if (outst) begin
            if ((e >= s_edge + 2) && lcd_done) begin
               outst = 1'b0; idle_edge = e + H + 1;
            end else if (e == s_edge + 1 + T) begin
               m_terr = 1'b1; m_force[m_reg] = 1'b1;
               outst = 1'b0; idle_edge = e + H + 1;
            end
         end
         df = m_dirty_face();
         ds = m_dirty_stats();
         exp_start = !outst && (e >= idle_edge) && (df || ds);
         if (exp_start) begin
            sel = (df && ds) ? !m_last : ds;
            if (sel) begin
               m_feed = clampv(feed_in); m_joy = clampv(joy_in); m_energy = clampv(energy_in);
               n_r1++;
            end else begin
               m_face = clampf(face_in);
            end
            m_force[sel] = 1'b0; m_last = sel; m_reg = sel;
            outst = 1'b1; s_edge = e; n_starts++;
            st_edge.push_back(e); st_reg.push_back(sel);
         end
      end
      #1;
      chk("lcd_start", lcd_start, exp_start);
      if (exp_start) chk("lcd_region", lcd_region, sel);
      if (!reset) chk("reset_region", lcd_region, 0);
      chk("face", face, m_face);
      chk("feed_value", feed_value, m_feed);
      chk("joy_value", joy_value, m_joy);
      chk("energy_value", energy_value, m_energy);
      chk("busy", busy, outst || (cyc < idle_edge - 1));
      chk("timeout_err", timeout_err, m_terr);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 2500; i++) begin
         if (settled()) break;
         tick();
      end
      chk("wait_idle_bound", settled(), 1);
   endtask

   initial begin
      int n0, r0, s0;

      // Reset with all inputs zero, then both regions are redrawn in order.
      reset = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      wait_idle();
      chk("startup_count", n_starts, 2);
      if (n_starts >= 2) begin
         chk("startup_first_region", st_reg[0], 0);
         chk("startup_second_region", st_reg[1], 1);
         chk("startup_gap", st_edge[1] - st_edge[0], 5 + H + 2);
      end

      // Face change alone: region 0 on the next cycle, no region-1 redraw.
      n0 = n_starts;
      face_in = 4'd3;
      tick();
      chk("face_only_start", lcd_start, 1);
      chk("face_only_region", lcd_region, 0);
      chk("face_only_value", face, 3);
      wait_idle();
      chk("face_only_count", n_starts, n0 + 1);

      // Stats changes during an in-flight face redraw coalesce into one update.
      r0 = n_r1;
      face_in = 4'd5; tick();
      feed_in = 4'd2; tick();
      joy_in = 4'd4; tick();
      energy_in = 4'd1; tick();
      wait_idle();
      chk("coalesce_r1_count", n_r1 - r0, 1);
      chk("coalesce_feed", feed_value, 2);
      chk("coalesce_joy", joy_value, 4);
      chk("coalesce_energy", energy_value, 1);

      // A change after a stats redraw is issued gets its own follow-up redraw.
      r0 = n_r1;
      feed_in = 4'd3; tick();
      joy_in = 4'd0; tick();
      wait_idle();
      chk("inflight_r1_count", n_r1 - r0, 2);
      chk("inflight_joy", joy_value, 0);

      // Round-robin: face issued last, then both dirty -> stats first, then face.
      face_in = 4'd6; tick();
      wait_idle();
      face_in = 4'd7; feed_in = 4'd1; tick();
      chk("rr_first_region", lcd_region, 1);
      wait_idle();
      chk("rr_second_region", st_reg[st_reg.size() - 1], 0);

      // Clamping of out-of-range values.
      feed_in = 4'd7; face_in = 4'd12;
      wait_idle();
      chk("clamp_feed", feed_value, 5);
      chk("clamp_face", face, 8);

      // Withheld lcd_done: timeout, re-issue of the same region after holdoff.
      auto_done = 1'b0;
      joy_in = 4'd3; tick();
      s0 = cyc;
      chk("timeout_issue_region", lcd_region, 1);
      while (cyc < s0 + T) tick();
      chk("timeout_not_yet", timeout_err, 0);
      tick();
      chk("timeout_set", timeout_err, 1);
      auto_done = 1'b1;
      wait_idle();
      chk("timeout_reissue_region", st_reg[st_reg.size() - 1], 1);
      chk("timeout_reissue_gap", st_edge[st_edge.size() - 1] - s0, T + H + 2);

      // One-cycle reset clears the error and forces both regions again.
      n0 = n_starts;
      reset = 1'b0; tick();
      reset = 1'b1;
      chk("reset_clears_terr", timeout_err, 0);
      wait_idle();
      chk("reset_redraw_count", n_starts - n0, 2);
      chk("reset_redraw_first", st_reg[st_reg.size() - 2], 0);
      chk("reset_redraw_second", st_reg[st_reg.size() - 1], 1);

      // Randomized phase: input churn, varying done latency, stray done pulses, resets.
      spurious_en = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if (!outst) done_dly = $urandom_range(1, 12);
         if ($urandom_range(0, 9) < 3) begin
            case ($urandom_range(0, 3))
               0: face_in = 4'($urandom_range(0, 15));
               1: feed_in = 4'($urandom_range(0, 15));
               2: joy_in = 4'($urandom_range(0, 15));
               default: energy_in = 4'($urandom_range(0, 15));
            endcase
         end
         reset = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
         tick();
      end
      reset = 1'b1;
      spurious_en = 1'b0;
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
